// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handles mult/multu/div/divu over ITERS cycles, and mthi/mtlo in a single cycle.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_operation,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_dz_flag
);

    localparam int unsigned W         = DATA_WIDTH;
    localparam int unsigned ITERS     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_WIDTH = $clog2(ITERS) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits becoming quotient bits}.
    logic [2*W-1:0]       acc_q;
    logic [W-1:0]         mag_a_q;
    logic [W-1:0]         mag_b_q;
    logic [W-1:0]         raw_a_q;
    logic [W-1:0]         hi_q;
    logic [W-1:0]         lo_q;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 div_zero_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dz_q;

    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         start_mag_a;
    logic [W-1:0]         start_mag_b;

    // Operand magnitudes and signs for a newly issued operation
    always_comb begin
        op_signed   = ~i_operation[0];
        a_neg       = op_signed & i_data_a[W-1];
        b_neg       = op_signed & i_data_b[W-1];
        start_mag_a = a_neg ? -i_data_a : i_data_a;
        start_mag_b = b_neg ? -i_data_b : i_data_b;
    end

    logic [2*W-1:0] acc_step;
    logic [W:0]     rem_t;
    logic [W:0]     sum_t;

    // One CALC iteration: BITS_PER_CYCLE shift-add or restoring-divide steps
    always_comb begin
        acc_step = acc_q;
        rem_t    = '0;
        sum_t    = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (is_div_q) begin
                rem_t    = {acc_step[2*W-1:W], acc_step[W-1]};
                acc_step = {acc_step[2*W-2:0], 1'b0};
                if (rem_t >= {1'b0, mag_b_q}) begin
                    rem_t       = rem_t - {1'b0, mag_b_q};
                    acc_step[0] = 1'b1;
                end
                acc_step[2*W-1:W] = rem_t[W-1:0];
            end else begin
                sum_t    = {1'b0, acc_step[2*W-1:W]} + (acc_step[0] ? {1'b0, mag_a_q} : '0);
                acc_step = {sum_t, acc_step[W-1:1]};
            end
        end
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // Sign correction applied in FIX
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            raw_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Flush in the issue cycle suppresses any request.
                    if (i_start && !i_flush) begin
                        case (i_operation)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div_q   <= i_operation[1];
                                neg_res_q  <= a_neg ^ b_neg;
                                neg_rem_q  <= a_neg;
                                div_zero_q <= i_operation[1] & (i_data_b == '0);
                                raw_a_q    <= i_data_a;
                                mag_a_q    <= start_mag_a;
                                mag_b_q    <= start_mag_b;
                                acc_q      <= i_operation[1] ? {{W{1'b0}}, start_mag_a}
                                                             : {{W{1'b0}}, start_mag_b};
                                cnt_q      <= '0;
                                busy_q     <= 1'b1;
                                state_q    <= StCalc;
                            end
                            3'd4:    hi_q <= i_data_a;
                            3'd5:    lo_q <= i_data_a;
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    if (i_flush) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(ITERS - 1)) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (!i_flush) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            hi_q <= prod_fix[2*W-1:W];
                            lo_q <= prod_fix[W-1:0];
                        end else if (div_zero_q) begin
                            hi_q <= raw_a_q;
                            lo_q <= '1;
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_hi      = hi_q;
    assign o_lo      = lo_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_dz_flag = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: radix-2 and radix-4 instances share stimulus
// and are compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    logic [W-1:0] hi1, lo1, hi2, lo2;
    logic         busy1, done1, dz1, busy2, done2, dz2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operation(op),
        .i_data_a(a), .i_data_b(b), .i_flush(flush),
        .o_hi(hi1), .o_lo(lo1), .o_busy(busy1), .o_done(done1), .o_dz_flag(dz1)
    );

    muldiv_unit #(.DATA_WIDTH(W), .BITS_PER_CYCLE(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operation(op),
        .i_data_a(a), .i_data_b(b), .i_flush(flush),
        .o_hi(hi2), .o_lo(lo2), .o_busy(busy2), .o_done(done2), .o_dz_flag(dz2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference results from plain integer arithmetic
    function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edz);
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        edz = 1'b0;
        ehi = '0;
        elo = '0;
        p   = '0;
        case (mop)
            3'd0: begin
                sp = longint'($signed(ma)) * longint'($signed(mb));
                p  = sp;
                ehi = p[63:32];
                elo = p[31:0];
            end
            3'd1: begin
                p   = {32'b0, ma} * {32'b0, mb};
                ehi = p[63:32];
                elo = p[31:0];
            end
            3'd2: begin
                if (mb == 0) begin
                    ehi = ma; elo = '1; edz = 1'b1;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    ehi = '0; elo = 32'h8000_0000;
                end else begin
                    sa = ma; sb = mb;
                    elo = sa / sb;
                    ehi = sa % sb;
                end
            end
            default: begin
                if (mb == 0) begin
                    ehi = ma; elo = '1; edz = 1'b1;
                end else begin
                    elo = ma / mb;
                    ehi = ma % mb;
                end
            end
        endcase
    endfunction

    // Issue one mult/div, optionally pulse an MTHI request at cycle inj, check both DUTs
    task automatic run_op(input logic [2:0] o, input logic [31:0] oa, input logic [31:0] ob,
                          input int inj);
        logic [31:0] ehi, elo, hb1, lb1, hb2, lb2, h1, l1, h2, l2;
        logic        edz, d1, d2, early;
        int          lat1, lat2, bc1, bc2, ov;
        model(o, oa, ob, ehi, elo, edz);
        hb1 = hi1; lb1 = lo1; hb2 = hi2; lb2 = lo2;
        h1 = '0; l1 = '0; h2 = '0; l2 = '0; d1 = 1'b0; d2 = 1'b0;
        early = 1'b0; lat1 = -1; lat2 = -1; ov = 0;
        op = o; a = oa; b = ob; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        bc1 = int'(busy1); bc2 = int'(busy2);
        for (int n = 1; n <= 40; n++) begin
            if (n == inj) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done1 && lat1 < 0) begin
                lat1 = n; h1 = hi1; l1 = lo1; d1 = dz1;
            end else if (lat1 < 0 && (hi1 !== hb1 || lo1 !== lb1)) begin
                early = 1'b1;
            end
            if (done2 && lat2 < 0) begin
                lat2 = n; h2 = hi2; l2 = lo2; d2 = dz2;
            end else if (lat2 < 0 && (hi2 !== hb2 || lo2 !== lb2)) begin
                early = 1'b1;
            end
            if (busy1) bc1++;
            if (busy2) bc2++;
            if ((busy1 && done1) || (busy2 && done2)) ov++;
        end
        start = 1'b0;
        check("lat_r1", 64'(lat1), 64'd33);
        check("lat_r2", 64'(lat2), 64'd17);
        check("busy_len_r1", 64'(bc1), 64'd33);
        check("busy_len_r2", 64'(bc2), 64'd17);
        check("busy_done_overlap", 64'(ov), 64'd0);
        check("hilo_early_change", 64'(early), 64'd0);
        check("hi_r1", 64'(h1), 64'(ehi));
        check("lo_r1", 64'(l1), 64'(elo));
        check("dz_r1", 64'(d1), 64'(edz));
        check("hi_r2", 64'(h2), 64'(ehi));
        check("lo_r2", 64'(l2), 64'(elo));
        check("dz_r2", 64'(d2), 64'(edz));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] hb, lb, hb2, lb2, ehi, elo;
        logic        edz, seen;
        int          cnt, lat;

        // Reset state
        repeat (3) tick();
        check("rst_hi", 64'(hi1), 64'd0);
        check("rst_lo", 64'(lo1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_dz", 64'(dz1), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_m3x5_hi", 64'(hi1), 64'hFFFF_FFFF);
        check("mult_m3x5_lo", 64'(lo1), 64'hFFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi", 64'(hi2), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo2), 64'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2_lo", 64'(lo1), 64'hFFFF_FFFD);
        check("div_m7_2_hi", 64'(hi1), 64'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min_m1_lo", 64'(lo1), 64'h8000_0000);
        check("div_min_m1_hi", 64'(hi1), 64'h0);
        run_op(3'd3, 32'h1234_5678, 32'd0, 0);
        check("divu_dz_hi", 64'(hi1), 64'h1234_5678);
        check("divu_dz_lo", 64'(lo1), 64'hFFFF_FFFF);
        run_op(3'd2, 32'd1000, 32'd7, 5);
        check("div_mthi_ignored", 64'(hi1), 64'd6);

        // Flush mid-CALC: no done, HI/LO retained
        hb = hi1; lb = lo1; hb2 = hi2; lb2 = lo2;
        op = 3'd1; a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done1 || done2) cnt++;
        end
        check("flush_no_done", 64'(cnt), 64'd0);
        check("flush_busy", 64'(busy1), 64'd0);
        check("flush_hi_r1", 64'(hi1), 64'(hb));
        check("flush_lo_r1", 64'(lo1), 64'(lb));
        check("flush_hi_r2", 64'(hi2), 64'(hb2));
        check("flush_lo_r2", 64'(lo2), 64'(lb2));

        // MTLO while idle
        op = 3'd5; a = 32'h0000_CAFE; start = 1'b1;
        tick();
        start = 1'b0;
        check("mtlo_lo", 64'(lo1), 64'hCAFE);
        check("mtlo_busy", 64'(busy1), 64'd0);
        check("mtlo_hi_kept", 64'(hi1), 64'(hb));

        // MTHI with flush in the same cycle is suppressed; then a plain MTHI
        op = 3'd4; a = 32'h1234_0000; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("mthi_flush_suppressed", 64'(hi1), 64'(hb));
        op = 3'd4; a = 32'h5555_AAAA; start = 1'b1;
        tick();
        start = 1'b0;
        check("mthi_hi", 64'(hi1), 64'h5555_AAAA);

        // No-op encodings are ignored
        op = 3'd6; a = 32'h1111_1111; b = 32'h2; start = 1'b1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("nop_busy", 64'(busy1), 64'd0);
        check("nop_hi", 64'(hi1), 64'h5555_AAAA);
        check("nop_lo", 64'(lo1), 64'hCAFE);

        // Start in the done cycle is accepted
        op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0; cnt = 0;
        while (!seen && cnt < 40) begin
            tick();
            cnt++;
            if (done1) seen = 1'b1;
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        model(3'd2, 32'd100, 32'hFFFF_FFF9, ehi, elo, edz);
        op = 3'd2; a = 32'd100; b = 32'hFFFF_FFF9; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_accepted", 64'(busy1), 64'd1);
        seen = 1'b0; lat = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (done1) seen = 1'b1;
        end
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hi", 64'(hi1), 64'(ehi));
        check("b2b_lo", 64'(lo1), 64'(elo));
        repeat (5) tick();

        // Asynchronous reset mid-CALC clears everything immediately
        op = 3'd0; a = 32'h0001_2345; b = 32'hFFFF_0003; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi1), 64'd0);
        check("arst_lo", 64'(lo1), 64'd0);
        check("arst_busy", 64'(busy1), 64'd0);
        check("arst_done", 64'(done1), 64'd0);
        check("arst_dz", 64'(dz1), 64'd0);
        check("arst_busy_r2", 64'(busy2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized operations against the model
        for (int k = 0; k < 30; k++) begin
            run_op(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS core. Sits beside the ALU in the EX stage.
- Executes mult, multu, div and divu into architectural HI/LO registers. Also handles mthi/mtlo.
- Raises a busy signal so the pipeline stalls mfhi/mflo and any further muldiv issue.
- Generalised in data width and in radix (result bits retired per cycle).

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Must be even.
- BITS_PER_CYCLE, 1, bits retired per iteration (1 or 2). DATA_WIDTH must be divisible by it.
- ITERS, DATA_WIDTH/BITS_PER_CYCLE, derived localparam: iteration count.
- CNT_WIDTH, log(2, ITERS)+1, derived localparam: counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  issue request, sampled on the rising edge.
- i_operation  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 are no-op.
- i_data_a  input  DATA_WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source).
- i_data_b  input  DATA_WIDTH  rt operand (multiplier / divisor).
- i_flush  input  1  cancels the in-flight operation.
- o_hi  output  DATA_WIDTH  HI register.
- o_lo  output  DATA_WIDTH  LO register.
- o_busy  output  1  operation in flight.
- o_done  output  1  one-cycle pulse when HI/LO are updated by mult/div.
- o_dz_flag  output  1  divide-by-zero, valid with o_done.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_hi=0, o_lo=0, o_busy=0, o_done=0, o_dz_flag=0, state=IDLE.
  - Takes effect immediately, including mid-operation.
  - Internal working registers are reset to 0.
- State machine IDLE -> CALC -> FIX -> IDLE:
  - IDLE:
    - i_start with op 0-3 on edge E0: latch operands, counter=0, go to CALC. o_busy=1 from E0.
    - Signed ops latch operand magnitudes and record result signs. Sign of product/quotient = a_sign^b_sign; sign of remainder = a_sign.
    - MTHI/MTLO: o_hi (resp. o_lo) <= i_data_a at E0. State stays IDLE, o_busy stays 0.
    - Ops 6,7: ignored.
  - CALC:
    - One iteration per edge.
    - Multiply: shift-add of BITS_PER_CYCLE multiplier bits into a 2*DATA_WIDTH accumulator.
    - Divide: restoring, BITS_PER_CYCLE quotient bits per edge.
    - After ITERS edges (edge E(ITERS)), go to FIX.
  - FIX, one edge E(ITERS+1):
    - Apply sign correction (two's-complement negate where required).
    - Write HI/LO: multiply HI=product[2W-1:W], LO=product[W-1:0]; divide LO=quotient, HI=remainder.
    - Go to IDLE, o_busy=0, o_done=1 for exactly one cycle.
- Latency: start edge to o_done high = ITERS+1 edges (33 for defaults).
  - o_busy is high for exactly ITERS+1 cycles and is never high together with o_done.
- Divide semantics:
  - Quotient truncates toward zero.
  - Divisor 0: HI=i_data_a as latched (raw, unsigned view), LO=all ones, o_dz_flag=1 with o_done. Full latency still applies.
  - Signed MIN / -1: LO=MIN, HI=0. No flag.
- i_start while o_busy=1: ignored, any op including MTHI/MTLO. The pipeline must hold the request.
- i_start in the o_done cycle: accepted normally (state is IDLE).
- i_flush=1:
  - In CALC or FIX: go to IDLE at that edge, HI/LO unchanged, no o_done.
  - Flush beats start on the same edge.
  - In IDLE: no effect. An MTHI/MTLO issued in the same cycle is suppressed.
- HI/LO change only on FIX, MTHI/MTLO or reset.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> o_done 33 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFF1, o_busy high for 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat with BITS_PER_CYCLE=2 -> same values, done after 17 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, o_dz_flag=0.
- DIVU a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF, o_dz_flag=1 coincident with o_done.
- Start MULTU 7*9, i_flush at cycle 10 -> no o_done, HI/LO retain prior values. Then MTLO a=0xCAFE while idle -> o_lo=0xCAFE next cycle, o_busy=0.
- Start DIV, pulse i_start MTHI at cycle 5 -> ignored, HI = remainder. Assert i_rst_n=0 mid-CALC on a second op -> all outputs 0 immediately. New start in the o_done cycle is accepted.
